// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//
// Multi-cycle sequencer for the SimpleRISC mul / div / mod instructions.
// Sits beside the EX-stage ALU: accepts one operation, holds the pipeline with
// a single stall line while it runs an iterative shift-add multiply or a
// restoring divide on operand magnitudes, then applies the sign and returns a
// WIDTH-bit result together with a one-cycle done pulse.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high; aborts any operation without done
//   start       request from EX; only sampled in IDLE or DONE
//   op          2'b00 mul, 2'b01 div, 2'b10 mod, 2'b11 treated as mul
//   a           signed operand 1 (multiplicand / dividend)
//   b           signed operand 2 (multiplier / divisor)
//   abort       pipeline flush; kills an in-flight operation, blocks start
//   busy        high while in PREP, CALC or FIX (registered)
//   done        one-cycle pulse in DONE, result valid (registered)
//   result      registered result; holds until the next operation's DONE
//   stall_pipe  combinational: busy | (start & (IDLE | DONE))
//
// Optional build macro
//   MULDIV_EARLY_OUT_EN  when defined, a multiply leaves CALC as soon as the
//                        remaining multiplier register is zero at the start
//                        of a cycle. div/mod latency is unaffected.
//
// Latency (macro undefined): start sampled at edge E0, done high after edge
// E(WIDTH+2).
// -----------------------------------------------------------------------------
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             stall_pipe
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(WIDTH - 1);

    // Two's-complement negate; magnitude of MIN wraps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] v);
        neg_f = ~v + ONE_W;
    endfunction

    // Magnitude of a signed value, returned as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] abs_f(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            abs_f = neg_f(v);
        end else begin
            abs_f = v;
        end
    endfunction

    // FSM state
    state_t            state_r;
    state_t            state_nx_s;

    // Latched request
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [1:0]        op_r;

    // Shared datapath:
    //   mul: x_r = multiplicand (shifts left), y_r = multiplier (shifts right),
    //        acc_r = partial product
    //   div: x_r = quotient / dividend shift register, y_r = divisor magnitude,
    //        acc_r = partial remainder
    logic [WIDTH-1:0]  x_r;
    logic [WIDTH-1:0]  y_r;
    logic [WIDTH-1:0]  acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sign_r;
    logic              div0_r;

    // Registered outputs
    logic              busy_r;
    logic              done_r;
    logic [WIDTH-1:0]  result_r;

    // Combinational helpers
    logic              idle_or_done_s;
    logic              accept_s;
    logic              is_div_s;
    logic              is_mod_s;
    logic              is_mul_s;
    logic              last_iter_s;
    logic              early_out_s;
    logic [WIDTH:0]    shift_s;
    logic [WIDTH:0]    trial_s;
    logic [WIDTH-1:0]  mag_s;
    logic [WIDTH-1:0]  fix_val_s;
    logic              busy_nx_s;
    logic              done_nx_s;

    assign idle_or_done_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
    // abort outranks start: a flush on the same edge discards the request.
    assign accept_s       = start && !abort && idle_or_done_s;

    assign is_div_s       = (op_r == 2'b01);
    assign is_mod_s       = (op_r == 2'b10);
    assign is_mul_s       = !is_div_s && !is_mod_s;
    assign last_iter_s    = (cnt_r == LAST_C);

`ifdef MULDIV_EARLY_OUT_EN
    // Nothing left to add once the multiplier has shifted out to zero.
    assign early_out_s    = is_mul_s && (y_r == ZERO_W);
`else
    assign early_out_s    = 1'b0;
`endif

    // Restoring divide step: shift next dividend bit into the remainder and
    // try subtracting the divisor; a borrow (bit WIDTH set) means restore.
    assign shift_s        = {acc_r, x_r[WIDTH-1]};
    assign trial_s        = shift_s - {1'b0, y_r};

    // Final sign application. MIN/-1 and MIN mod -1 fall out of the
    // magnitude arithmetic; only divide-by-zero quotient is forced.
    always_comb begin
        mag_s     = acc_r;
        fix_val_s = ZERO_W;
        if (is_div_s) begin
            mag_s = x_r;
        end else begin
            mag_s = acc_r;
        end
        if (is_div_s && div0_r) begin
            fix_val_s = ONES_W;
        end else if (sign_r) begin
            fix_val_s = neg_f(mag_s);
        end else begin
            fix_val_s = mag_s;
        end
    end

    // Next-state logic; reset is applied in the state register.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_PREP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_CALC: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (early_out_s || last_iter_s) begin
                    state_nx_s = ST_FIX;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept_s) begin
                    state_nx_s = ST_PREP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so busy/done can be registered.
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            ST_PREP, ST_CALC, ST_FIX: begin
                busy_nx_s = 1'b1;
                done_nx_s = 1'b0;
            end
            ST_DONE: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b1;
            end
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // State register with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r      <= ZERO_W;
            b_r      <= ZERO_W;
            op_r     <= 2'b00;
            x_r      <= ZERO_W;
            y_r      <= ZERO_W;
            acc_r    <= ZERO_W;
            cnt_r    <= ZERO_C;
            sign_r   <= 1'b0;
            div0_r   <= 1'b0;
            result_r <= ZERO_W;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                    end else begin
                        a_r  <= a_r;
                        b_r  <= b_r;
                        op_r <= op_r;
                    end
                end
                ST_PREP: begin
                    // mod follows the dividend's sign; mul/div the xor.
                    if (is_mod_s) begin
                        sign_r <= a_r[WIDTH-1];
                    end else begin
                        sign_r <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
                    end
                    div0_r <= (b_r == ZERO_W);
                    x_r    <= abs_f(a_r);
                    y_r    <= abs_f(b_r);
                    acc_r  <= ZERO_W;
                    cnt_r  <= ZERO_C;
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + ONE_C;
                    if (is_mul_s) begin
                        if (y_r[0]) begin
                            acc_r <= acc_r + x_r;
                        end else begin
                            acc_r <= acc_r;
                        end
                        x_r <= {x_r[WIDTH-2:0], 1'b0};
                        y_r <= {1'b0, y_r[WIDTH-1:1]};
                    end else begin
                        if (!trial_s[WIDTH]) begin
                            acc_r <= trial_s[WIDTH-1:0];
                            x_r   <= {x_r[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_r <= shift_s[WIDTH-1:0];
                            x_r   <= {x_r[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_FIX: begin
                    // A flush here must leave the previous result visible.
                    if (!abort) begin
                        result_r <= fix_val_s;
                    end else begin
                        result_r <= result_r;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;
    assign stall_pipe = busy_r | (start & idle_or_done_s);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH = 32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_muldiv_seq;

    localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int MUL53_EDGES = 5;
    localparam int MUL50_EDGES = 3;
`else
    localparam int MUL53_EDGES = 34;
    localparam int MUL50_EDGES = 34;
`endif

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         stall_pipe;

    int errors;
    int checks;

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .stall_pipe (stall_pipe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one full cycle: rising edge, then the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request at the current falling edge; returns just after E0.
    task automatic launch(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        chk({tag, ".stall"}, {31'd0, stall_pipe}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    endtask

    // Count edges after E0 until done; ends at the falling edge inside DONE.
    task automatic wait_done(input string tag, input logic [31:0] exp,
                             input int exp_edges);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        chk({tag, ".edges"}, n, exp_edges);
        chk({tag, ".result"}, result, exp);
        chk({tag, ".busy_in_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int exp_edges);
        launch(tag, o, x, y);
        wait_done(tag, exp, exp_edges);
        cyc();
        chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int seen;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        op     = 2'b00;
        a      = 32'd0;
        b      = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.stall", {31'd0, stall_pipe}, 32'd0);

        // abort in IDLE blocks a simultaneous start
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        chk("idle_abort.busy", {31'd0, busy}, 32'd0);

        // mul 31 * 29
        run_op("mul31x29", 2'b00, 32'h0000001F, 32'h0000001D, 32'h00000383, 34);

        // div -100 / 7, then back-to-back mod from DONE
        launch("div-100/7", 2'b01, 32'hFFFFFF9C, 32'd7);
        wait_done("div-100/7", 32'hFFFFFFF2, 34);
        run_op("mod-100/7", 2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34);

        // divide by zero and overflow corners
        run_op("div5/0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 34);
        run_op("mod5/0", 2'b10, 32'd5, 32'd0, 32'h00000005, 34);
        run_op("modMIN/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34);
        run_op("divMIN/-1", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);

        // mul 6*7 aborted at E10: no done, result unchanged
        launch("abort", 2'b00, 32'd6, 32'd7);
        repeat (9) cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen++;
            cyc();
        end
        chk("abort.no_done", seen, 0);
        chk("abort.result_kept", result, 32'h80000000);
        run_op("mul3x3", 2'b00, 32'd3, 32'd3, 32'd9, 34);

        // reset at E20 of a div; start held in reset is ignored
        launch("rst_mid", 2'b01, 32'd100, 32'd7);
        repeat (19) cyc();
        reset = 1'b1;
        start = 1'b1;
        cyc();
        chk("rst_mid.busy", {31'd0, busy}, 32'd0);
        chk("rst_mid.done", {31'd0, done}, 32'd0);
        chk("rst_mid.result", result, 32'd0);
        cyc();
        chk("rst_hold.busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        cyc();
        start = 1'b0;
        chk("rst_release.busy", {31'd0, busy}, 32'd1);
        wait_done("rst_release", 32'd14, 34);
        cyc();

        // multiply latency with and without early-out; div unaffected
        run_op("mul5x3", 2'b00, 32'd5, 32'd3, 32'd15, MUL53_EDGES);
        run_op("mul5x0", 2'b00, 32'd5, 32'd0, 32'd0, MUL50_EDGES);
        run_op("div100/7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
        run_op("op11_mul", 2'b11, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFF4, MUL53_EDGES == 5 ? 6 : 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
